// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline types and forwarding-select constants
package pipe_pkg;

   localparam int REG_ADDR_W = 5;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   localparam reg_addr_t ZERO_REG = '0;

   localparam logic [1:0] FWD_RF  = 2'd0;
   localparam logic [1:0] FWD_MEM = 2'd1;
   localparam logic [1:0] FWD_WB  = 2'd2;

endpackage

// File: rtl/md_scoreboard.sv
// rtl/md_scoreboard.sv - tracks one in-flight multi-cycle op and its destination
module md_scoreboard
   import pipe_pkg::*;
#(
   parameter int ADDR_W = REG_ADDR_W,
   parameter int MD_LAT = 4
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              MdStart,
   input  logic [ADDR_W-1:0] EXrd,
   output logic              MdBusy,
   output logic              MdDone,
   output logic [ADDR_W-1:0] MdRd,
   output logic              MdErr
);

   localparam logic [3:0] LAT = 4'(MD_LAT);

   logic [3:0]        md_cnt;
   logic [ADDR_W-1:0] md_rd;
   logic              md_err;

   // A start arriving while the counter is non-zero (including the done cycle) is dropped.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         md_cnt <= 4'd0;
         md_rd  <= ADDR_W'(ZERO_REG);
         md_err <= 1'b0;
      end else if (md_cnt != 4'd0) begin
         md_cnt <= md_cnt - 4'd1;
         if (MdStart)
            md_err <= 1'b1;
      end else if (MdStart) begin
         md_cnt <= LAT;
         md_rd  <= EXrd;
      end
   end

   // Status is masked while reset is held so the stall logic sees an idle tracker.
   assign MdBusy = ~Rst & (md_cnt != 4'd0);
   assign MdDone = ~Rst & (md_cnt == 4'd1);
   assign MdErr  = ~Rst & md_err;
   assign MdRd   = md_rd;

endmodule

// File: rtl/hazard_forward_unit.sv
// rtl/hazard_forward_unit.sv - operand forwarding, load-use and multi-cycle hazard control
module hazard_forward_unit
   import pipe_pkg::*;
#(
   parameter int ADDR_W    = REG_ADDR_W,
   parameter int MD_LAT    = 4,
   parameter int ID_FWD_EN = 1,
   parameter int CNT_W     = 32
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic [ADDR_W-1:0] IDrs,
   input  logic [ADDR_W-1:0] IDrt,
   input  logic              IDUsesRs,
   input  logic              IDUsesRt,
   input  logic              IDRegWrite,
   input  logic [ADDR_W-1:0] IDrd,
   input  logic              IDMdOp,
   input  logic [ADDR_W-1:0] EXrs,
   input  logic [ADDR_W-1:0] EXrt,
   input  logic              EXUsesRs,
   input  logic              EXUsesRt,
   input  logic [ADDR_W-1:0] EXrd,
   input  logic              EXRegWrite,
   input  logic              EXMemRead,
   input  logic              MdStart,
   input  logic [ADDR_W-1:0] Memrd,
   input  logic [ADDR_W-1:0] WBrd,
   input  logic              MemRegWrite,
   input  logic              WBRegWrite,
   output logic [1:0]        FwdA,
   output logic [1:0]        FwdB,
   output logic              FwdIdA,
   output logic              FwdIdB,
   output logic              Stall,
   output logic              FlushEx,
   output logic              MdBusy,
   output logic              MdDone,
   output logic              MdErr,
   output logic [CNT_W-1:0]  StallCount
);

   logic [ADDR_W-1:0] md_rd;
   logic              load_use;
   logic              md_hazard;
   logic [CNT_W-1:0]  stall_cnt;

   md_scoreboard #(
      .ADDR_W (ADDR_W),
      .MD_LAT (MD_LAT)
   ) u_md_scoreboard (
      .Clk     (Clk),
      .Rst     (Rst),
      .MdStart (MdStart),
      .EXrd    (EXrd),
      .MdBusy  (MdBusy),
      .MdDone  (MdDone),
      .MdRd    (md_rd),
      .MdErr   (MdErr)
   );

   // r0 is hardwired, so it never creates a dependence.
   function automatic logic hit(input logic [ADDR_W-1:0] dst, input logic [ADDR_W-1:0] src);
      return (dst != ADDR_W'(ZERO_REG)) && (dst == src);
   endfunction

   always_comb begin
      FwdA = FWD_RF;
      if (MemRegWrite && EXUsesRs && hit(Memrd, EXrs))
         FwdA = FWD_MEM;
      else if (WBRegWrite && EXUsesRs && hit(WBrd, EXrs))
         FwdA = FWD_WB;

      FwdB = FWD_RF;
      if (MemRegWrite && EXUsesRt && hit(Memrd, EXrt))
         FwdB = FWD_MEM;
      else if (WBRegWrite && EXUsesRt && hit(WBrd, EXrt))
         FwdB = FWD_WB;

      FwdIdA = (ID_FWD_EN != 0) && WBRegWrite && IDUsesRs && hit(WBrd, IDrs);
      FwdIdB = (ID_FWD_EN != 0) && WBRegWrite && IDUsesRt && hit(WBrd, IDrt);

      load_use = EXMemRead &&
                 ((IDUsesRs && hit(EXrd, IDrs)) || (IDUsesRt && hit(EXrd, IDrt)));

      md_hazard = MdBusy &&
                  ((IDUsesRs && hit(md_rd, IDrs)) ||
                   (IDUsesRt && hit(md_rd, IDrt)) ||
                   (IDRegWrite && hit(md_rd, IDrd)) ||
                   IDMdOp);

      Stall   = load_use | md_hazard;
      FlushEx = load_use | md_hazard;
   end

   always_ff @(posedge Clk) begin
      if (Rst)
         stall_cnt <= '0;
      else if (Stall && (stall_cnt != {CNT_W{1'b1}}))
         stall_cnt <= stall_cnt + CNT_W'(1);
   end

   assign StallCount = Rst ? '0 : stall_cnt;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb/tb_hazard_forward_unit.sv - randomized and directed checks against a behavioural model
module tb_hazard_forward_unit;

   logic       Clk = 1'b0;
   logic       Rst;
   logic [4:0] IDrs, IDrt, IDrd, EXrs, EXrt, EXrd, Memrd, WBrd;
   logic       IDUsesRs, IDUsesRt, IDRegWrite, IDMdOp;
   logic       EXUsesRs, EXUsesRt, EXRegWrite, EXMemRead, MdStart;
   logic       MemRegWrite, WBRegWrite;

   logic [1:0]  FwdA, FwdB;
   logic        FwdIdA, FwdIdB, Stall, FlushEx, MdBusy, MdDone, MdErr;
   logic [31:0] StallCount;

   logic [1:0]  s_FwdA, s_FwdB;
   logic        s_FwdIdA, s_FwdIdB, s_Stall, s_FlushEx, s_MdBusy, s_MdDone, s_MdErr;
   logic [2:0]  s_StallCount;

   int checks = 0;
   int errors = 0;

   int md_left = 0;
   int md_rd   = 0;
   bit md_err  = 0;
   int stalls  = 0;

   always #5 Clk = ~Clk;

   hazard_forward_unit u_dut (
      .Clk(Clk), .Rst(Rst), .IDrs(IDrs), .IDrt(IDrt), .IDUsesRs(IDUsesRs), .IDUsesRt(IDUsesRt),
      .IDRegWrite(IDRegWrite), .IDrd(IDrd), .IDMdOp(IDMdOp), .EXrs(EXrs), .EXrt(EXrt),
      .EXUsesRs(EXUsesRs), .EXUsesRt(EXUsesRt), .EXrd(EXrd), .EXRegWrite(EXRegWrite),
      .EXMemRead(EXMemRead), .MdStart(MdStart), .Memrd(Memrd), .WBrd(WBrd),
      .MemRegWrite(MemRegWrite), .WBRegWrite(WBRegWrite), .FwdA(FwdA), .FwdB(FwdB),
      .FwdIdA(FwdIdA), .FwdIdB(FwdIdB), .Stall(Stall), .FlushEx(FlushEx), .MdBusy(MdBusy),
      .MdDone(MdDone), .MdErr(MdErr), .StallCount(StallCount)
   );

   hazard_forward_unit #(.ID_FWD_EN(0), .CNT_W(3)) u_small (
      .Clk(Clk), .Rst(Rst), .IDrs(IDrs), .IDrt(IDrt), .IDUsesRs(IDUsesRs), .IDUsesRt(IDUsesRt),
      .IDRegWrite(IDRegWrite), .IDrd(IDrd), .IDMdOp(IDMdOp), .EXrs(EXrs), .EXrt(EXrt),
      .EXUsesRs(EXUsesRs), .EXUsesRt(EXUsesRt), .EXrd(EXrd), .EXRegWrite(EXRegWrite),
      .EXMemRead(EXMemRead), .MdStart(MdStart), .Memrd(Memrd), .WBrd(WBrd),
      .MemRegWrite(MemRegWrite), .WBRegWrite(WBRegWrite), .FwdA(s_FwdA), .FwdB(s_FwdB),
      .FwdIdA(s_FwdIdA), .FwdIdB(s_FwdIdB), .Stall(s_Stall), .FlushEx(s_FlushEx),
      .MdBusy(s_MdBusy), .MdDone(s_MdDone), .MdErr(s_MdErr), .StallCount(s_StallCount)
   );

   task automatic check(input string tag, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int fwd_sel(input int src, input bit uses, input bit mw, input int mrd,
                                  input bit ww, input int wrd);
      if (!uses || src == 0) return 0;
      if (mw && mrd == src) return 1;
      if (ww && wrd == src) return 2;
      return 0;
   endfunction

   task automatic clear_inputs();
      {IDrs, IDrt, IDrd, EXrs, EXrt, EXrd, Memrd, WBrd} = '0;
      {IDUsesRs, IDUsesRt, IDRegWrite, IDMdOp} = '0;
      {EXUsesRs, EXUsesRt, EXRegWrite, EXMemRead, MdStart} = '0;
      {MemRegWrite, WBRegWrite} = '0;
   endtask

   // Compare every output of both instances with the model, then advance the model one edge.
   task automatic step(input string tag);
      int  srcs[$];
      bit  busy, lu, mh, stall;
      int  e_idfa, e_idfb;
      @(negedge Clk);
      srcs = {};
      if (IDUsesRs) srcs.push_back(int'(IDrs));
      if (IDUsesRt) srcs.push_back(int'(IDrt));
      busy = !Rst && md_left > 0;
      lu = EXMemRead && EXrd != 0 && (int'(EXrd) inside {srcs});
      mh = busy && (IDMdOp || (md_rd != 0 &&
           ((md_rd inside {srcs}) || (IDRegWrite && int'(IDrd) == md_rd))));
      stall = lu || mh;
      e_idfa = (WBRegWrite && IDUsesRs && WBrd != 0 && WBrd == IDrs) ? 1 : 0;
      e_idfb = (WBRegWrite && IDUsesRt && WBrd != 0 && WBrd == IDrt) ? 1 : 0;

      check({tag, ".FwdA"}, FwdA, fwd_sel(EXrs, EXUsesRs, MemRegWrite, Memrd, WBRegWrite, WBrd));
      check({tag, ".FwdB"}, FwdB, fwd_sel(EXrt, EXUsesRt, MemRegWrite, Memrd, WBRegWrite, WBrd));
      check({tag, ".FwdIdA"}, FwdIdA, e_idfa);
      check({tag, ".FwdIdB"}, FwdIdB, e_idfb);
      check({tag, ".Stall"}, Stall, stall);
      check({tag, ".FlushEx"}, FlushEx, stall);
      check({tag, ".MdBusy"}, MdBusy, busy);
      check({tag, ".MdDone"}, MdDone, busy && md_left == 1);
      check({tag, ".MdErr"}, MdErr, !Rst && md_err);
      check({tag, ".StallCount"}, StallCount, Rst ? 0 : stalls);
      check({tag, ".s_FwdIdA"}, s_FwdIdA, 0);
      check({tag, ".s_FwdIdB"}, s_FwdIdB, 0);
      check({tag, ".s_Stall"}, s_Stall, stall);
      check({tag, ".s_StallCount"}, s_StallCount, Rst ? 0 : (stalls > 7 ? 7 : stalls));

      if (Rst) begin
         md_left = 0; md_rd = 0; md_err = 0; stalls = 0;
      end else begin
         if (stall) stalls++;
         if (md_left > 0) begin
            if (MdStart) md_err = 1;
            md_left--;
         end else if (MdStart) begin
            md_left = 4;
            md_rd   = int'(EXrd);
         end
      end
      @(posedge Clk);
      #1;
   endtask

   initial begin
      clear_inputs();
      Rst = 1'b1;
      @(posedge Clk);
      #1;
      step("reset");
      Rst = 1'b0;
      #1;
      check("reset.MdBusy", MdBusy, 0);
      check("reset.StallCount", StallCount, 0);
      step("idle");

      // Forwarding priority
      Memrd = 5; WBrd = 5; EXrs = 5; MemRegWrite = 1; WBRegWrite = 1; EXUsesRs = 1;
      #1 check("fwd.mem", FwdA, 1);
      step("fwd_mem");
      MemRegWrite = 0;
      #1 check("fwd.wb", FwdA, 2);
      step("fwd_wb");
      EXrs = 0; Memrd = 0; WBrd = 0; MemRegWrite = 1;
      #1 check("fwd.r0", FwdA, 0);
      step("fwd_r0");

      // Load-use: one stall, then resolved by MEM forwarding
      clear_inputs();
      EXMemRead = 1; EXRegWrite = 1; EXrd = 8; IDUsesRt = 1; IDrt = 8;
      #1 check("lu.stall", Stall, 1);
      check("lu.flush", FlushEx, 1);
      step("lu");
      clear_inputs();
      MemRegWrite = 1; Memrd = 8; EXrt = 8; EXUsesRt = 1; IDUsesRt = 1; IDrt = 3;
      #1 check("lu.fwdb", FwdB, 1);
      check("lu.count", StallCount, 1);
      check("lu.release", Stall, 0);
      step("lu_next");

      // Multi-cycle dependence
      clear_inputs();
      MdStart = 1; EXrd = 9; EXRegWrite = 1;
      step("md_start");
      clear_inputs();
      IDUsesRs = 1; IDrs = 9;
      for (int i = 1; i <= 5; i++) begin
         #1 check("md.stall", Stall, (i <= 4) ? 1 : 0);
         check("md.done", MdDone, (i == 4) ? 1 : 0);
         step("md_dep");
      end

      // Second start while busy is dropped and flagged
      clear_inputs();
      MdStart = 1; EXrd = 3;
      step("err_start");
      EXrd = 6;
      step("err_second");
      MdStart = 0; IDUsesRs = 1; IDrs = 6;
      #1 check("err.flag", MdErr, 1);
      check("err.rd_kept", Stall, 0);
      for (int i = 2; i <= 5; i++) begin
         #1 check("err.busy", MdBusy, (i <= 4) ? 1 : 0);
         step("err_run");
      end
      check("err.sticky", MdErr, 1);

      // Reset in mid-operation
      clear_inputs();
      MdStart = 1; EXrd = 4;
      step("rst_start");
      MdStart = 0;
      step("rst_c4");
      step("rst_c3");
      Rst = 1;
      #1 check("rst.busy_during", MdBusy, 0);
      step("rst_mid");
      Rst = 0;
      #1 check("rst.busy", MdBusy, 0);
      check("rst.err", MdErr, 0);
      check("rst.count", StallCount, 0);
      step("rst_after");

      // Saturation on the narrow counter, and disabled ID forwarding
      clear_inputs();
      EXMemRead = 1; EXrd = 8; IDUsesRs = 1; IDrs = 8; WBRegWrite = 1; WBrd = 8;
      for (int i = 0; i < 9; i++) step("sat");
      #1 check("sat.small", s_StallCount, 7);
      check("sat.wide", StallCount, 9);
      check("idfwd.off", s_FwdIdA, 0);
      check("idfwd.on", FwdIdA, 1);
      step("sat_end");

      // Random traffic over a small register range so that matches are frequent
      for (int n = 0; n < 500; n++) begin
         Rst = ($urandom_range(0, 39) == 0);
         IDrs = 5'($urandom_range(0, 3)); IDrt = 5'($urandom_range(0, 3));
         IDrd = 5'($urandom_range(0, 3)); EXrs = 5'($urandom_range(0, 3));
         EXrt = 5'($urandom_range(0, 3)); EXrd = 5'($urandom_range(0, 3));
         Memrd = 5'($urandom_range(0, 3)); WBrd = 5'($urandom_range(0, 3));
         {IDUsesRs, IDUsesRt, IDRegWrite, EXUsesRs, EXUsesRt, EXRegWrite} = 6'($urandom);
         {MemRegWrite, WBRegWrite, EXMemRead} = 3'($urandom);
         IDMdOp  = ($urandom_range(0, 5) == 0);
         MdStart = ($urandom_range(0, 5) == 0);
         step("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
